// File: rtl/win_pkg.sv
// Shared types and width helpers for the 3x3 window scheduler.
package win_pkg;

    localparam int PIX_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } state_e;

    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int row_w(input int img_h);
        return width_for(img_h);
    endfunction

    function automatic int col_w(input int img_w);
        return width_for(img_w);
    endfunction

endpackage

// File: rtl/line_buf.sv
// One-row pixel delay: combinational read of the old value, write of the new
// value at the same address on the clock edge.
module line_buf import win_pkg::*; #(
    parameter int DEPTH = 64,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [width_for(DEPTH)-1:0] addr_i,
    input  logic [PIX_W-1:0]            wdata_i,
    output logic [PIX_W-1:0]            rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // NOTE: storage has no reset so it maps onto plain RAM; every row is
    // rewritten before the window logic ever reads it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/win3x3_sched.sv
// Raster-to-3x3-window scheduler: two line buffers build the neighbourhood and
// a {valid,row,col} delay line aligns coordinates with the downstream pipeline.
module win3x3_sched import win_pkg::*; #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int PIX_W    = PIX_W_DEF,
    parameter int PIPE_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [PIX_W-1:0]          in_pix,
    output logic                      in_ready,
    output logic [PIX_W-1:0]          p1,
    output logic [PIX_W-1:0]          p2,
    output logic [PIX_W-1:0]          p3,
    output logic [PIX_W-1:0]          p4,
    output logic [PIX_W-1:0]          p5,
    output logic [PIX_W-1:0]          p6,
    output logic [PIX_W-1:0]          p7,
    output logic [PIX_W-1:0]          p8,
    output logic [PIX_W-1:0]          p9,
    output logic                      win_valid,
    output logic [row_w(IMG_H)-1:0]   win_row,
    output logic [col_w(IMG_W)-1:0]   win_col,
    output logic                      res_valid,
    output logic [row_w(IMG_H)-1:0]   res_row,
    output logic [col_w(IMG_W)-1:0]   res_col,
    output logic                      frame_done,
    output logic                      err
);

    localparam int RW = row_w(IMG_H);
    localparam int CW = col_w(IMG_W);
    localparam int DW = width_for(PIPE_LAT + 1);

    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_DONE   = RW'(IMG_H - 2);
    localparam logic [RW-1:0] ROW_TWO    = RW'(2);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_DONE   = CW'(IMG_W - 2);
    localparam logic [CW-1:0] COL_TWO    = CW'(2);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic            err_d;

    logic            take;
    logic            restart;
    logic            dl_clr;
    logic            win_d;
    logic [RW-1:0]   pos_row;
    logic [CW-1:0]   pos_col;

    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    // Column index 0 = top row (r-2), 1 = middle (r-1), 2 = bottom (r).
    logic [2:0][PIX_W-1:0] col_a_q;
    logic [2:0][PIX_W-1:0] col_b_q;
    logic [2:0][PIX_W-1:0] new_col;

    logic [PIPE_LAT-1:0]         dl_v_q;
    logic [PIPE_LAT-1:0][RW-1:0] dl_r_q;
    logic [PIPE_LAT-1:0][CW-1:0] dl_c_q;

    // NOTE: every signal this block drives gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        take     = 1'b0;
        restart  = 1'b0;
        dl_clr   = 1'b0;
        pos_row  = row_q;
        pos_col  = col_q;
        in_ready = (state_q != DRAIN);

        case (state_q)
            IDLE: begin
                if (in_valid && in_sof) begin
                    take    = 1'b1;
                    restart = 1'b1;
                end
            end
            FILL, RUN: begin
                if (in_valid) begin
                    take = 1'b1;
                    if (in_sof) begin
                        restart = 1'b1;
                        err_d   = 1'b1;
                        dl_clr  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start-of-frame pixel is always position (0,0), whatever the counters say.
        if (restart) begin
            pos_row = '0;
            pos_col = '0;
        end

        if (take) begin
            if (pos_row == ROW_LAST && pos_col == COL_LAST) begin
                state_d = DRAIN;
                cnt_d   = '0;
                row_d   = '0;
                col_d   = '0;
            end else if (pos_col == COL_LAST) begin
                col_d   = '0;
                row_d   = pos_row + 1'b1;
                state_d = (row_d >= ROW_TWO) ? RUN : FILL;
            end else begin
                col_d   = pos_col + 1'b1;
                row_d   = pos_row;
                state_d = (pos_row >= ROW_TWO) ? RUN : FILL;
            end
        end

        win_d = take && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            err     <= err_d;
        end
    end

    line_buf #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb0 (
        .clk     (clk),
        .we_i    (take),
        .addr_i  (pos_col),
        .wdata_i (in_pix),
        .rdata_o (lb0_rd)
    );

    line_buf #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb1 (
        .clk     (clk),
        .we_i    (take),
        .addr_i  (pos_col),
        .wdata_i (lb0_rd),
        .rdata_o (lb1_rd)
    );

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = in_pix;

    // Two shadow columns shift on every pixel; the visible window only loads
    // when a complete interior window forms, so p1..p9 hold across gaps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_a_q   <= '0;
            col_b_q   <= '0;
            p1        <= '0;
            p2        <= '0;
            p3        <= '0;
            p4        <= '0;
            p5        <= '0;
            p6        <= '0;
            p7        <= '0;
            p8        <= '0;
            p9        <= '0;
            win_row   <= '0;
            win_col   <= '0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= win_d;
            if (take) begin
                col_a_q <= col_b_q;
                col_b_q <= new_col;
            end
            if (win_d) begin
                p1      <= col_a_q[0];
                p2      <= col_b_q[0];
                p3      <= new_col[0];
                p4      <= col_a_q[1];
                p5      <= col_b_q[1];
                p6      <= new_col[1];
                p7      <= col_a_q[2];
                p8      <= col_b_q[2];
                p9      <= new_col[2];
                win_row <= pos_row - 1'b1;
                win_col <= pos_col - 1'b1;
            end
        end
    end

    // Abandoning a frame drops only the valid bits; stale coordinates are harmless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dl_v_q <= '0;
            dl_r_q <= '0;
            dl_c_q <= '0;
        end else begin
            dl_r_q[0] <= win_row;
            dl_c_q[0] <= win_col;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_r_q[i] <= dl_r_q[i-1];
                dl_c_q[i] <= dl_c_q[i-1];
            end
            if (dl_clr) begin
                dl_v_q <= '0;
            end else begin
                dl_v_q[0] <= win_valid;
                for (int i = 1; i < PIPE_LAT; i++) begin
                    dl_v_q[i] <= dl_v_q[i-1];
                end
            end
        end
    end

    assign res_valid  = dl_v_q[PIPE_LAT-1];
    assign res_row    = dl_r_q[PIPE_LAT-1];
    assign res_col    = dl_c_q[PIPE_LAT-1];
    assign frame_done = res_valid && (res_row == ROW_DONE) && (res_col == COL_DONE);

endmodule

// File: tb/tb_win3x3_sched.sv
// Directed bench for win3x3_sched on a 4x4 image with pixel value 16*r+c.
module tb_win3x3_sched;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pix = '0;
    logic       in_ready;
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic       win_valid;
    logic [1:0] win_row, win_col;
    logic       res_valid;
    logic [1:0] res_row, res_col;
    logic       frame_done;
    logic       err;

    typedef struct {
        int              cyc;
        int              r;
        int              c;
        logic [8:0][7:0] p;
    } win_t;

    typedef struct {
        int cyc;
        int r;
        int c;
    } res_t;

    win_t win_log[$];
    res_t res_log[$];
    int   cyc = 0;
    int   fd_cnt, err_cnt, gap_viol, fd_misalign;
    int   total = 0;
    int   bad = 0;

    win3x3_sched #(
        .IMG_W    (W),
        .IMG_H    (H),
        .PIX_W    (8),
        .PIPE_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pix     (in_pix),
        .in_ready   (in_ready),
        .p1         (p1),
        .p2         (p2),
        .p3         (p3),
        .p4         (p4),
        .p5         (p5),
        .p6         (p6),
        .p7         (p7),
        .p8         (p8),
        .p9         (p9),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .res_valid  (res_valid),
        .res_row    (res_row),
        .res_col    (res_col),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        win_log.delete();
        res_log.delete();
        fd_cnt      = 0;
        err_cnt     = 0;
        gap_viol    = 0;
        fd_misalign = 0;
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        win_t w;
        res_t rr;
        bit   acc;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (win_valid) begin
            w.cyc  = cyc;
            w.r    = int'(win_row);
            w.c    = int'(win_col);
            w.p[0] = p1; w.p[1] = p2; w.p[2] = p3;
            w.p[3] = p4; w.p[4] = p5; w.p[5] = p6;
            w.p[6] = p7; w.p[7] = p8; w.p[8] = p9;
            win_log.push_back(w);
            if (!acc) gap_viol++;
        end
        if (res_valid) begin
            rr.cyc = cyc;
            rr.r   = int'(res_row);
            rr.c   = int'(res_col);
            res_log.push_back(rr);
        end
        if (frame_done) begin
            fd_cnt++;
            if (!(res_valid && res_row == 2'd2 && res_col == 2'd2)) fd_misalign++;
        end
        if (err) err_cnt++;
    endtask

    task automatic send_pix(input int r, input int c, input bit sof, input bit gap);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pix   = 8'(16 * r + c);
        tick();
        if (gap) begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            tick();
        end
    endtask

    task automatic send_prefix(input int n);
        for (int i = 0; i < n; i++) send_pix(i / W, i % W, i == 0, 1'b0);
    endtask

    task automatic send_frame(input bit gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_pix(r, c, (r == 0) && (c == 0), gap);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) tick();
    endtask

    // Expected windows for one clean frame, in raster order of centres.
    task automatic check_frame(input int wbase, input int rbase, input string tag);
        for (int k = 0; k < 4; k++) begin
            int cr, cc;
            cr = 1 + k / 2;
            cc = 1 + k % 2;
            if (win_log.size() > wbase + k) begin
                check($sformatf("%s_w%0d_row", tag, k), win_log[wbase+k].r, cr);
                check($sformatf("%s_w%0d_col", tag, k), win_log[wbase+k].c, cc);
                for (int j = 0; j < 9; j++)
                    check($sformatf("%s_w%0d_p%0d", tag, k, j + 1), win_log[wbase+k].p[j],
                          16 * (cr - 1 + j / 3) + (cc - 1 + j % 3));
                if (res_log.size() > rbase + k) begin
                    check($sformatf("%s_r%0d_row", tag, k), res_log[rbase+k].r, cr);
                    check($sformatf("%s_r%0d_col", tag, k), res_log[rbase+k].c, cc);
                    check($sformatf("%s_r%0d_lat", tag, k), res_log[rbase+k].cyc,
                          win_log[wbase+k].cyc + LAT);
                end
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_win_valid", win_valid, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_p5", p5, 0);
        check("rst_win_row", win_row, 0);
        @(negedge clk);
        rst = 1'b1;
        idle_ticks(2);

        // Basic frame with drain timing
        clear_logs();
        send_frame(1'b0);
        check("drain1_ready", in_ready, 0);
        tick();
        check("drain2_ready", in_ready, 0);
        tick();
        check("post_drain_ready", in_ready, 1);
        check("post_drain_res", res_valid, 1);
        check("post_drain_fd", frame_done, 1);
        idle_ticks(3);
        check("basic_nwin", win_log.size(), 4);
        check("basic_nres", res_log.size(), 4);
        check("basic_fd", fd_cnt, 1);
        check("basic_fd_align", fd_misalign, 0);
        check("basic_err", err_cnt, 0);
        check_frame(0, 0, "basic");
        if (win_log.size() == 4) begin
            check("basic_last_p5", win_log[3].p[4], 8'h22);
            check("basic_last_p9", win_log[3].p[8], 8'h33);
        end

        // Same frame with in_valid toggling
        clear_logs();
        send_frame(1'b1);
        idle_ticks(6);
        check("gap_nwin", win_log.size(), 4);
        check("gap_nres", res_log.size(), 4);
        check("gap_viol", gap_viol, 0);
        check("gap_fd", fd_cnt, 1);
        check_frame(0, 0, "gap");

        // in_sof at (2,1): abandoned frame, then restarted frame completes
        clear_logs();
        send_prefix(9);
        send_frame(1'b0);
        idle_ticks(6);
        check("sof21_err", err_cnt, 1);
        check("sof21_nwin", win_log.size(), 4);
        check("sof21_nres", res_log.size(), 4);
        check("sof21_fd", fd_cnt, 1);
        check_frame(0, 0, "sof21");

        // in_sof at (3,0) with two windows in flight: their results are dropped
        clear_logs();
        send_prefix(12);
        send_frame(1'b0);
        idle_ticks(6);
        check("sof30_err", err_cnt, 1);
        check("sof30_nwin", win_log.size(), 6);
        check("sof30_nres", res_log.size(), 4);
        check("sof30_fd", fd_cnt, 1);
        check_frame(2, 0, "sof30");

        // IDLE ignores in_valid without in_sof
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_sof   = 1'b0;
            in_pix   = 8'(8'hA0 + i);
            tick();
        end
        check("idle_ready", in_ready, 1);
        check("idle_nwin", win_log.size(), 0);
        send_frame(1'b0);
        idle_ticks(6);
        check("idle_err", err_cnt, 0);
        check("idle_nwin_after", win_log.size(), 4);
        check("idle_fd", fd_cnt, 1);
        check_frame(0, 0, "idle");

        // Reset mid-RUN
        clear_logs();
        send_prefix(11);
        check("pre_rst_win", win_valid, 1);
        rst = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        check("mrst_win_valid", win_valid, 0);
        check("mrst_p1", p1, 0);
        check("mrst_p5", p5, 0);
        check("mrst_p9", p9, 0);
        check("mrst_win_row", win_row, 0);
        check("mrst_win_col", win_col, 0);
        check("mrst_res_valid", res_valid, 0);
        check("mrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        idle_ticks(2);
        clear_logs();
        send_frame(1'b0);
        idle_ticks(6);
        check("mrst_nwin", win_log.size(), 4);
        if (win_log.size() > 0) check("mrst_first_p1", win_log[0].p[0], 8'h00);
        check("mrst_fd", fd_cnt, 1);
        check_frame(0, 0, "mrst");

        // Back-to-back frames
        clear_logs();
        send_frame(1'b0);
        tick();
        tick();
        check("b2b_ready", in_ready, 1);
        send_frame(1'b0);
        idle_ticks(6);
        check("b2b_nwin", win_log.size(), 8);
        check("b2b_nres", res_log.size(), 8);
        check("b2b_fd", fd_cnt, 2);
        check("b2b_fd_align", fd_misalign, 0);
        check("b2b_err", err_cnt, 0);
        check_frame(0, 0, "b2b1");
        check_frame(4, 4, "b2b2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
